// File: rtl/pwm_duty_sequencer.sv
// pwm_duty_sequencer: ramps the PWM duty toward a host or button target, one step per STEP_PERIODS PWM periods
// Ports: clk, rst (async, active-high); period_end (PWM wrap pulse);
//   tgt_valid/tgt_ready/tgt_duty (host target handshake); inc_pulse, dec_pulse (button steps);
//   abort (freeze duty); duty (to PWM comparator); busy (ramping); done (target reached pulse).
// Optional: define SOFT_START_EN to ramp to INIT_DUTY automatically after reset.
module pwm_duty_sequencer #(
  parameter int DUTY_W = 4,
  parameter int DUTY_MAX = 10,
  parameter int STEP_PERIODS = 2,
  parameter int INIT_DUTY = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              period_end,
  input  logic              tgt_valid,
  output logic              tgt_ready,
  input  logic [DUTY_W-1:0] tgt_duty,
  input  logic              inc_pulse,
  input  logic              dec_pulse,
  input  logic              abort,
  output logic [DUTY_W-1:0] duty,
  output logic              busy,
  output logic              done
);
  localparam int CW = $clog2(STEP_PERIODS + 1);
  localparam logic [DUTY_W-1:0] MAX = DUTY_W'(DUTY_MAX);
  localparam logic [DUTY_W-1:0] INIT = (INIT_DUTY > DUTY_MAX) ? MAX : DUTY_W'(INIT_DUTY);
  // Count preloaded to LAST so the first step after entering RAMP lands on the next period_end.
  localparam logic [CW-1:0] LAST = CW'(STEP_PERIODS - 1);
  typedef enum logic {IDLE, RAMP} state_t;
`ifdef SOFT_START_EN
  localparam state_t RST_STATE = (INIT == '0) ? IDLE : RAMP;
  localparam logic [DUTY_W-1:0] RST_TGT = INIT;
  localparam logic [CW-1:0] RST_PCNT = LAST;
`else
  localparam state_t RST_STATE = IDLE;
  localparam logic [DUTY_W-1:0] RST_TGT = '0;
  localparam logic [CW-1:0] RST_PCNT = '0;
`endif
  state_t state, state_n;
  logic [DUTY_W-1:0] target, target_n, duty_n, req, step;
  logic [CW-1:0] pcnt, pcnt_n;
  logic done_n;
  assign tgt_ready = (state == IDLE);
  // Host target wins over button pulses; buttons saturate at 0 and DUTY_MAX.
  assign req = tgt_valid ? ((tgt_duty > MAX) ? MAX : tgt_duty)
             : inc_pulse ? ((duty >= MAX) ? MAX : duty + DUTY_W'(1))
             : ((duty == '0) ? '0 : duty - DUTY_W'(1));
  assign step = (duty < target) ? duty + DUTY_W'(1) : duty - DUTY_W'(1);
  always_comb begin
    state_n = state;
    duty_n = duty;
    target_n = target;
    pcnt_n = pcnt;
    done_n = 1'b0;
    if (state == IDLE) begin
      if (tgt_valid || (inc_pulse ^ dec_pulse)) begin
        target_n = req;
        if (req != duty) begin
          state_n = RAMP;
          pcnt_n = LAST;
        end else begin
          done_n = tgt_valid;
        end
      end
    end else if (abort) begin
      state_n = IDLE;
      target_n = duty;
    end else if (period_end) begin
      if (pcnt == LAST) begin
        pcnt_n = '0;
        duty_n = step;
        if (step == target) begin
          state_n = IDLE;
          done_n = 1'b1;
        end
      end else begin
        pcnt_n = pcnt + CW'(1);
      end
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= RST_STATE;
      duty <= '0;
      target <= RST_TGT;
      pcnt <= RST_PCNT;
      busy <= (RST_STATE == RAMP);
      done <= 1'b0;
    end else begin
      state <= state_n;
      duty <= duty_n;
      target <= target_n;
      pcnt <= pcnt_n;
      busy <= (state_n == RAMP);
      done <= done_n;
    end
  end
endmodule
